// File: rtl/jtag_tap_param.sv
// IEEE 1149.1 TAP controller with configurable IR length and opcodes.
// Provides IDCODE, BYPASS, a USER read/write data register and an ABORT strobe.
module jtag_tap_param #(
    parameter int                  IR_WIDTH     = 4,
    parameter logic [31:0]         IDCODE_VALUE = 32'h000FAF01,
    parameter int                  USER_WIDTH   = 8,
    parameter logic [IR_WIDTH-1:0] OP_IDCODE    = 4'b1110,
    parameter logic [IR_WIDTH-1:0] OP_BYPASS    = '1,
    parameter logic [IR_WIDTH-1:0] OP_USER      = 4'b1010,
    parameter logic [IR_WIDTH-1:0] OP_ABORT     = 4'b1000
) (
    input  logic                  clk_tck,
    input  logic                  trst_n,
    input  logic                  tms,
    input  logic                  tdi,
    input  logic                  enable,
    output logic                  tdo,
    output logic                  tdo_en,
    output logic [IR_WIDTH-1:0]   ir_value,
    output logic [3:0]            tap_state,
    input  logic [USER_WIDTH-1:0] user_in,
    output logic [USER_WIDTH-1:0] user_out,
    output logic                  user_update,
    output logic                  abort_pulse
);

    typedef enum logic [3:0] {
        TLR = 4'd0,  RTI = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
        SH_DR = 4'd4, EX1_DR = 4'd5, PAU_DR = 4'd6, EX2_DR = 4'd7,
        UPD_DR = 4'd8, SEL_IR = 4'd9, CAP_IR = 4'd10, SH_IR = 4'd11,
        EX1_IR = 4'd12, PAU_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
    } tap_state_t;

    tap_state_t            r_state, w_next;
    logic [IR_WIDTH-1:0]   r_ir, r_ir_sr;
    logic [31:0]           r_id_sr;
    logic [USER_WIDTH-1:0] r_user_sr, r_user_out, w_user_shift;
    logic                  r_byp_sr;
    logic                  r_user_update, r_abort, r_tdo, r_tdo_en;

    logic w_cap_ir, w_sh_ir, w_cap_dr, w_sh_dr, w_enter_upd_ir, w_enter_upd_dr;
    logic w_enter_tlr, w_shifting, w_tdo_bit;
    logic w_sel_id, w_sel_user, w_sel_abort;

    always_ff @(posedge clk_tck or negedge trst_n) begin
        if (!trst_n) r_state <= TLR;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (!enable) begin
            w_next = TLR;
        end else begin
            case (r_state)
                TLR:    w_next = tms ? TLR    : RTI;
                RTI:    w_next = tms ? SEL_DR : RTI;
                SEL_DR: w_next = tms ? SEL_IR : CAP_DR;
                CAP_DR: w_next = tms ? EX1_DR : SH_DR;
                SH_DR:  w_next = tms ? EX1_DR : SH_DR;
                EX1_DR: w_next = tms ? UPD_DR : PAU_DR;
                PAU_DR: w_next = tms ? EX2_DR : PAU_DR;
                EX2_DR: w_next = tms ? UPD_DR : SH_DR;
                UPD_DR: w_next = tms ? SEL_DR : RTI;
                SEL_IR: w_next = tms ? TLR    : CAP_IR;
                CAP_IR: w_next = tms ? EX1_IR : SH_IR;
                SH_IR:  w_next = tms ? EX1_IR : SH_IR;
                EX1_IR: w_next = tms ? UPD_IR : PAU_IR;
                PAU_IR: w_next = tms ? EX2_IR : PAU_IR;
                EX2_IR: w_next = tms ? UPD_IR : SH_IR;
                UPD_IR: w_next = tms ? SEL_DR : RTI;
            endcase
        end
    end

    // Unknown opcodes fall through to the 1-bit bypass register.
    assign w_sel_id    = (r_ir == OP_IDCODE);
    assign w_sel_user  = !w_sel_id && (r_ir == OP_USER);
    assign w_sel_abort = !w_sel_id && !w_sel_user && (r_ir == OP_ABORT);

    always_comb begin
        w_cap_ir       = enable && (r_state == CAP_IR);
        w_sh_ir        = enable && (r_state == SH_IR);
        w_cap_dr       = enable && (r_state == CAP_DR);
        w_sh_dr        = enable && (r_state == SH_DR);
        w_enter_upd_ir = (w_next == UPD_IR);
        w_enter_upd_dr = (w_next == UPD_DR);
        w_enter_tlr    = (w_next == TLR);
        w_shifting     = (r_state == SH_DR) || (r_state == SH_IR);
        w_tdo_bit      = 1'b0;
        if (r_state == SH_IR)
            w_tdo_bit = r_ir_sr[0];
        else if (r_state == SH_DR)
            w_tdo_bit = w_sel_id ? r_id_sr[0] : (w_sel_user ? r_user_sr[0] : r_byp_sr);
    end

    generate
        if (USER_WIDTH == 1) begin : g_user1
            assign w_user_shift = tdi;
        end else begin : g_usern
            assign w_user_shift = {tdi, r_user_sr[USER_WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk_tck or negedge trst_n) begin
        if (!trst_n) begin
            r_ir_sr <= '0;
            r_ir    <= OP_IDCODE;
        end else begin
            if (w_cap_ir)     r_ir_sr <= {{(IR_WIDTH-1){1'b0}}, 1'b1};
            else if (w_sh_ir) r_ir_sr <= {tdi, r_ir_sr[IR_WIDTH-1:1]};
            if (w_enter_tlr)         r_ir <= OP_IDCODE;
            else if (w_enter_upd_ir) r_ir <= r_ir_sr;
        end
    end

    always_ff @(posedge clk_tck or negedge trst_n) begin
        if (!trst_n) begin
            r_id_sr   <= '0;
            r_user_sr <= '0;
            r_byp_sr  <= 1'b0;
        end else if (w_cap_dr) begin
            if (w_sel_id)        r_id_sr   <= IDCODE_VALUE;
            else if (w_sel_user) r_user_sr <= user_in;
            else                 r_byp_sr  <= 1'b0;
        end else if (w_sh_dr) begin
            if (w_sel_id)        r_id_sr   <= {tdi, r_id_sr[31:1]};
            else if (w_sel_user) r_user_sr <= w_user_shift;
            else                 r_byp_sr  <= tdi;
        end
    end

    // Side effects fire on the edge entering Update-DR so they are visible during that state.
    always_ff @(posedge clk_tck or negedge trst_n) begin
        if (!trst_n) begin
            r_user_out    <= '0;
            r_user_update <= 1'b0;
            r_abort       <= 1'b0;
        end else begin
            r_user_update <= w_enter_upd_dr && w_sel_user;
            r_abort       <= w_enter_upd_dr && w_sel_abort;
            if (w_enter_upd_dr && w_sel_user) r_user_out <= r_user_sr;
        end
    end

    always_ff @(negedge clk_tck or negedge trst_n) begin
        if (!trst_n) begin
            r_tdo    <= 1'b0;
            r_tdo_en <= 1'b0;
        end else begin
            r_tdo    <= w_tdo_bit;
            r_tdo_en <= w_shifting;
        end
    end

    assign tdo         = r_tdo;
    assign tdo_en      = r_tdo_en;
    assign ir_value    = r_ir;
    assign tap_state   = r_state;
    assign user_out    = r_user_out;
    assign user_update = r_user_update;
    assign abort_pulse = r_abort;

endmodule

// File: tb/tb_jtag_tap_param.sv
// Bench for jtag_tap_param: directed scenarios plus a random walk, all checked
// against a queue-based model of the TAP built from the state-transition table.
module tb_jtag_tap_param;
    localparam int          IRW    = 4;
    localparam int          UW     = 8;
    localparam logic [31:0] IDC    = 32'h000FAF01;
    localparam logic [3:0]  OP_ID  = 4'b1110;
    localparam logic [3:0]  OP_US  = 4'b1010;
    localparam logic [3:0]  OP_AB  = 4'b1000;

    logic           clk_tck = 1'b0;
    logic           trst_n;
    logic           tms, tdi, enable;
    logic           tdo, tdo_en;
    logic [IRW-1:0] ir_value;
    logic [3:0]     tap_state;
    logic [UW-1:0]  user_in, user_out;
    logic           user_update, abort_pulse;

    jtag_tap_param dut (
        .clk_tck(clk_tck), .trst_n(trst_n), .tms(tms), .tdi(tdi), .enable(enable),
        .tdo(tdo), .tdo_en(tdo_en), .ir_value(ir_value), .tap_state(tap_state),
        .user_in(user_in), .user_out(user_out), .user_update(user_update),
        .abort_pulse(abort_pulse)
    );

    always #5 clk_tck = ~clk_tck;

    int checks = 0;
    int errors = 0;

    // Reference model
    int            nxt1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
    int            nxt0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int            m_st;
    logic [IRW-1:0] m_ir;
    bit            m_irq[$];
    bit            m_drq[$];
    logic [UW-1:0] m_uout;
    bit            m_uupd, m_abort;
    bit            g_en;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_ir = OP_ID; m_uout = '0; m_uupd = 0; m_abort = 0;
        m_irq.delete(); m_drq.delete();
        for (int i = 0; i < IRW; i++) m_irq.push_back(1'b0);
        m_drq.push_back(1'b0);
    endtask

    task automatic model_edge(input bit t, input bit d);
        int ns;
        logic [IRW-1:0] irv;
        m_uupd = 0; m_abort = 0;
        if (!enable) begin
            m_st = 0; m_ir = OP_ID;
            return;
        end
        ns = t ? nxt1[m_st] : nxt0[m_st];
        case (m_st)
            10: begin
                m_irq.delete();
                for (int i = 0; i < IRW; i++) m_irq.push_back(i == 0);
            end
            11: begin void'(m_irq.pop_front()); m_irq.push_back(d); end
            3: begin
                m_drq.delete();
                if (m_ir == OP_ID)      for (int i = 0; i < 32; i++) m_drq.push_back(IDC[i]);
                else if (m_ir == OP_US) for (int i = 0; i < UW; i++) m_drq.push_back(user_in[i]);
                else                    m_drq.push_back(1'b0);
            end
            4: begin void'(m_drq.pop_front()); m_drq.push_back(d); end
            default: ;
        endcase
        if (ns == 8 && m_ir == OP_US) begin
            m_uupd = 1;
            for (int i = 0; i < UW; i++) m_uout[i] = m_drq[i];
        end
        if (ns == 8 && m_ir == OP_AB && m_ir != OP_ID && m_ir != OP_US) m_abort = 1;
        if (ns == 15) begin
            for (int i = 0; i < IRW; i++) irv[i] = m_irq[i];
            m_ir = irv;
        end
        if (ns == 0) m_ir = OP_ID;
        m_st = ns;
    endtask

    task automatic compare_all();
        bit etdo;
        etdo = (m_st == 4) ? m_drq[0] : ((m_st == 11) ? m_irq[0] : 1'b0);
        chk("tap_state",   64'(tap_state),   64'(m_st));
        chk("ir_value",    64'(ir_value),    64'(m_ir));
        chk("tdo",         64'(tdo),         64'(etdo));
        chk("tdo_en",      64'(tdo_en),      64'(m_st == 4 || m_st == 11));
        chk("user_out",    64'(user_out),    64'(m_uout));
        chk("user_update", 64'(user_update), 64'(m_uupd));
        chk("abort_pulse", 64'(abort_pulse), 64'(m_abort));
    endtask

    task automatic step(input bit t, input bit d);
        tms = t; tdi = d;
        @(posedge clk_tck);
        model_edge(t, d);
        @(negedge clk_tck); #1;
        compare_all();
    endtask

    // Called shortly after a falling edge; reset is checked while still asserted.
    task automatic do_reset();
        trst_n = 1'b0;
        #1;
        chk("rst_state",  64'(tap_state), 64'(0));
        chk("rst_ir",     64'(ir_value),  64'(OP_ID));
        chk("rst_tdo",    64'(tdo),       64'(0));
        chk("rst_tdo_en", 64'(tdo_en),    64'(0));
        chk("rst_uout",   64'(user_out),  64'(0));
        chk("rst_pulses", 64'({user_update, abort_pulse}), 64'(0));
        model_reset();
        #1 trst_n = 1'b1;
    endtask

    // Starts with tap in a shift state; samples tdo before each shifting edge.
    task automatic shift_vec(input logic [31:0] din, input int n, output logic [31:0] dout);
        dout = '0; g_en = 1;
        for (int i = 0; i < n; i++) begin
            dout[i] = tdo;
            g_en = g_en & tdo_en;
            step(i == n - 1, din[i]);
        end
        chk("tdo_en_all", 64'(g_en), 64'(1));
    endtask

    // From RTI: load IR and return to RTI.
    task automatic write_ir(input logic [IRW-1:0] v, output logic [31:0] cap);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        shift_vec(32'(v), IRW, cap);
        step(1, 0); step(0, 0);
    endtask

    string paths[16];
    logic [31:0] o;

    initial begin
        paths = '{"", "0", "01", "010", "0100", "0101", "01010", "010101", "01011",
                  "011", "0110", "01100", "01101", "011010", "0110101", "011011"};
        trst_n = 1'b0; tms = 1'b1; tdi = 1'b0; enable = 1'b1; user_in = '0;
        #11;
        chk("init_state",  64'(tap_state), 64'(0));
        chk("init_ir",     64'(ir_value),  64'(OP_ID));
        chk("init_tdo",    64'({tdo, tdo_en}), 64'(0));
        chk("init_outs",   64'({user_out, user_update, abort_pulse}), 64'(0));
        model_reset();
        #2 trst_n = 1'b1;

        // Five TMS=1 edges from each state
        for (int k = 0; k < 16; k++) begin
            do_reset();
            for (int i = 0; i < paths[k].len(); i++) step(paths[k][i] == "1", 0);
            chk("reach_state", 64'(tap_state), 64'(k));
            for (int i = 0; i < 5; i++) step(1, 0);
            chk("tms5_state", 64'(tap_state), 64'(0));
            chk("tms5_ir",    64'(ir_value),  64'(4'b1110));
        end

        // IDCODE readout
        do_reset();
        step(0, 0); step(1, 0); step(0, 0); step(0, 0);
        shift_vec($urandom, 32, o);
        chk("idcode", 64'(o), 64'(32'h000FAF01));
        step(1, 0); step(0, 0);

        // BYPASS
        write_ir(4'b1111, o);
        chk("ir_capture", 64'(o[3:0]), 64'(4'b0001));
        chk("ir_bypass",  64'(ir_value), 64'(4'b1111));
        step(1, 0); step(0, 0); step(0, 0);
        shift_vec(32'b1101, 4, o);
        chk("bypass_out", 64'(o[3:0]), 64'(4'b1010));
        step(1, 0); step(0, 0);

        // USER
        user_in = 8'h3C;
        write_ir(OP_US, o);
        step(1, 0); step(0, 0); step(0, 0);
        shift_vec(32'hA5, 8, o);
        chk("user_capture", 64'(o[7:0]), 64'(8'h3C));
        step(1, 0);
        chk("user_out_upd", 64'(user_out), 64'(8'hA5));
        chk("user_upd_hi",  64'(user_update), 64'(1));
        step(0, 0);
        chk("user_upd_lo",  64'(user_update), 64'(0));
        chk("user_out_hold", 64'(user_out), 64'(8'hA5));

        // ABORT
        write_ir(OP_AB, o);
        step(1, 0); step(0, 0); step(1, 0); step(1, 0);
        chk("abort_hi", 64'(abort_pulse), 64'(1));
        step(0, 0);
        chk("abort_lo", 64'(abort_pulse), 64'(0));

        // Unknown opcode acts as bypass
        write_ir(4'b0011, o);
        step(1, 0); step(0, 0); step(0, 0);
        shift_vec(32'b0110, 4, o);
        chk("unknown_bypass", 64'(o[3:0]), 64'(4'b1100));
        chk("unknown_no_abort", 64'(abort_pulse), 64'(0));
        step(1, 0); step(0, 0);

        // Reset in the middle of a USER shift
        write_ir(OP_US, o);
        user_in = 8'($urandom);
        step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 3; i++) step(0, 1'($urandom));
        chk("pre_rst_en", 64'(tdo_en), 64'(1));
        do_reset();

        // Dropping enable mid-shift
        step(0, 0);
        write_ir(OP_US, o);
        step(1, 0); step(0, 0); step(0, 0); step(0, 1);
        enable = 1'b0;
        step(0, 0);
        chk("en_drop_state", 64'(tap_state), 64'(0));
        chk("en_drop_ir",    64'(ir_value),  64'(OP_ID));
        enable = 1'b1;

        // Random walk
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end else begin
                enable  = ($urandom_range(0, 39) != 0);
                user_in = 8'($urandom);
                step($urandom_range(0, 99) < 35, 1'($urandom));
            end
        end
        enable = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/jtag_tap_param.md
Name: jtag_tap_param

Overview:
Parametrised IEEE 1149.1 TAP controller, the successor to the fixed 4-bit-IR IDCODE-only TAP.
- Generalised IR length, IDCODE value and instruction opcodes.
- Real IR and DR shift registers instead of a side byte transmitter.
- Adds BYPASS, a user read/write data register (USER) and an ABORT strobe.
- Sits between the chip JTAG pins and on-chip debug logic.

Parameters:
IR_WIDTH, 4, instruction register length (≥2)
IDCODE_VALUE, 32'h000FAF01, value captured for IDCODE; bit 0 must be 1
USER_WIDTH, 8, width of the USER data register (≥1)
OP_IDCODE, 4'b1110, IDCODE opcode (IR_WIDTH bits)
OP_BYPASS, all ones, BYPASS opcode
OP_USER, 4'b1010, USER opcode
OP_ABORT, 4'b1000, ABORT opcode

Ports:
clk_tck  in  1  TCK; the single clock
trst_n  in  1  asynchronous, active-low reset
tms  in  1  test mode select, sampled on posedge
tdi  in  1  test data in, sampled on posedge
enable  in  1  high: TAP runs; low: synchronously forced to TestLogicReset
tdo  out  1  test data out, changes on negedge
tdo_en  out  1  high while tdo carries shift data
ir_value  out  IR_WIDTH  current latched instruction
tap_state  out  4  current TAP state encoding
user_in  in  USER_WIDTH  value captured into USER DR at Capture-DR
user_out  out  USER_WIDTH  value latched at Update-DR under USER
user_update  out  1  one-cycle pulse when user_out is written
abort_pulse  out  1  one-cycle pulse at Update-DR under ABORT

Behaviour:
- Reset (trst_n low, async):
  - tap_state=TestLogicReset(0); ir_value=OP_IDCODE.
  - IR/DR shift registers=0; user_out=0.
  - user_update=0, abort_pulse=0, tdo=0, tdo_en=0.
- State encoding, 4-bit binary:
  - TLR=0, RTI=1, SelDR=2, CapDR=3, ShDR=4, Ex1DR=5, PauseDR=6, Ex2DR=7, UpdDR=8
  - SelIR=9, CapIR=10, ShIR=11, Ex1IR=12, PauseIR=13, Ex2IR=14, UpdIR=15
- Transitions on posedge when enable=1 (TMS=1 / TMS=0):
  - TLR→TLR/RTI; RTI→SelDR/RTI; SelDR→SelIR/CapDR; SelIR→TLR/CapIR
  - CapX→Ex1X/ShX; ShX→Ex1X/ShX; Ex1X→UpdX/PauseX; PauseX→Ex2X/PauseX; Ex2X→UpdX/ShX
  - UpdX→SelDR/RTI
  - No other exits from ShiftDR: no auto-exit when the register drains.
- Five consecutive TMS=1 posedges reach TLR from any state.
- enable=0: next state TLR; IR is forced as in TLR; shift registers hold.
- In TLR, ir_value is forced to OP_IDCODE every cycle.
- IR path:
  - CapIR loads shift reg with {0…0,01} (LSB=1).
  - ShIR shifts right: tdi→MSB, LSB→tdo.
  - UpdIR copies shift reg into ir_value.
- DR selection by ir_value:
  - OP_IDCODE: 32-bit reg, CapDR loads IDCODE_VALUE.
  - OP_USER: USER_WIDTH reg, CapDR loads user_in.
  - OP_BYPASS, OP_ABORT and any unknown opcode: 1-bit bypass reg, CapDR loads 0.
- DR shift: in ShDR, each posedge shifts right, tdi→MSB, LSB first out; length = selected register width.
- UpdDR:
  - OP_USER: user_out ← USER shift reg, and user_update=1 for exactly the next cycle.
  - OP_ABORT: abort_pulse=1 for one cycle.
  - IDCODE and BYPASS: no side effect.
- tdo/tdo_en, updated on negedge:
  - In ShDR/ShIR: tdo = LSB of the active shift reg, tdo_en=1.
  - Otherwise: tdo=0, tdo_en=0.
  - First bit is valid on the negedge after entering ShX.
- Pause states hold the shift regs; Ex2→ShX resumes without recapture.
- Simultaneous trst_n low and any activity: reset wins immediately.
- Reset mid-shift: partial data is discarded; user_out and ir_value revert to their reset values.

Test Plan:
- Reset then 5×TMS=1 from each of the 16 states → tap_state=0, ir_value=1110.
- TLR, TMS 0,1,0,0 then 32 shifts with TMS=1 on the last → tdo LSB-first = 0x000FAF01, tdo_en high for all 32 bits.
- Shift IR 1111 (BYPASS) from CapIR → first IR bits out are 1,0,0,0. Then DR-shift tdi pattern 1,0,1,1 → tdo = 0,1,0,1 (one-cycle delay).
- IR=1010, DR-shift 0xA5 (with user_in=0x3C) → tdo yields 0x3C. At UpdDR, user_out=0xA5 and user_update is a single-cycle pulse.
- IR=1000, pass through UpdDR → abort_pulse high exactly one cycle; unknown IR 0011 behaves as BYPASS.
- Assert trst_n low mid-ShDR of USER → tap_state=0, tdo=0, tdo_en=0, user_out=0 immediately. Also drop enable mid-ShDR → TLR on the next posedge.
